// File: rtl/axis_i2s_slave_rx.sv
// I2S slave receiver: samples an externally clocked I2S bus and emits left/right words on AXI-Stream.
// Build with I2S_SLV_LEFT_JUSTIFIED_EN defined for left-justified framing (no one-bit delay).
module axis_i2s_slave_rx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdin,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StWaitSync, StSkip, StShift, StDone} state_e;

  // Input synchronisers and SCLK edge detect
  logic [1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
  logic       sclk_prev_q;

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      sclk_sync_q <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], i2s_sclk};
      lrck_sync_q <= {lrck_sync_q[0], i2s_lrck};
      sdin_sync_q <= {sdin_sync_q[0], i2s_sdin};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  logic rise, lrck_s, sdin_s;
  assign rise   = sclk_sync_q[1] & ~sclk_prev_q;
  assign lrck_s = lrck_sync_q[1];
  assign sdin_s = sdin_sync_q[1];

  // Slot framing FSM
  state_e                state_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  slot_lr_q;
  logic                  lrck_last_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] push_data_q;
  logic                  push_last_q;

  logic                  lr_chg;
  logic                  start_slot;
  logic [CntW-1:0]       count_inc;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] first_bit;
  logic [DATA_WIDTH-1:0] partial_word;

  assign lr_chg       = rise && (lrck_s != lrck_last_q);
  // Out of sync, only a transition into the left slot starts a frame.
  assign start_slot   = lr_chg && ((state_q != StWaitSync) || !lrck_s);
  assign count_inc    = count_q + CntW'(1);
  assign shift_next   = {shift_q[DATA_WIDTH-2:0], sdin_s};
  assign first_bit    = {{(DATA_WIDTH - 1){1'b0}}, sdin_s};
  assign partial_word = shift_q << (CntW'(DATA_WIDTH) - count_q);

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q     <= StWaitSync;
      count_q     <= '0;
      shift_q     <= '0;
      slot_lr_q   <= 1'b0;
      lrck_last_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_last_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (rise) begin
        lrck_last_q <= lrck_s;
        if (start_slot) begin
          // A slot cut short still delivers what it captured, MSB-aligned.
          if (state_q == StShift) begin
            push_q      <= 1'b1;
            push_data_q <= partial_word;
            push_last_q <= slot_lr_q;
          end
          slot_lr_q <= lrck_s;
`ifdef I2S_SLV_LEFT_JUSTIFIED_EN
          state_q <= StShift;
          shift_q <= first_bit;
          count_q <= CntW'(1);
`else
          state_q <= StSkip;
          count_q <= '0;
`endif
        end else begin
          unique case (state_q)
            StSkip: begin
              state_q <= StShift;
              shift_q <= first_bit;
              count_q <= CntW'(1);
            end
            StShift: begin
              shift_q <= shift_next;
              count_q <= count_inc;
              if (count_inc == CntW'(DATA_WIDTH)) begin
                push_q      <= 1'b1;
                push_data_q <= shift_next;
                push_last_q <= slot_lr_q;
                state_q     <= StDone;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output FIFO with stereo pairing
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       fill_q;
  logic                have_left_q;
  logic                drop_pair_q;
  logic                overflow_q;

  logic [PtrW:0] free_cnt;
  logic          left_fits;
  logic          wr_en;
  logic          rd_en;
  logic          drop;

  assign free_cnt  = (PtrW + 1)'(FIFO_DEPTH) - fill_q;
  assign left_fits = free_cnt >= (PtrW + 1)'(2);
  // A right word follows its left; reserving two slots keeps pairs whole.
  assign wr_en     = push_q && (push_last_q ? have_left_q : left_fits);
  assign drop      = push_q && (push_last_q ? drop_pair_q : !left_fits);
  assign rd_en     = m_axis_valid && m_axis_ready;

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      have_left_q <= 1'b0;
      drop_pair_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   fill_q <= fill_q + (PtrW + 1)'(1);
        2'b01:   fill_q <= fill_q - (PtrW + 1)'(1);
        default: fill_q <= fill_q;
      endcase
      if (push_q) begin
        if (push_last_q) begin
          have_left_q <= 1'b0;
          drop_pair_q <= 1'b0;
        end else begin
          have_left_q <= left_fits;
          drop_pair_q <= !left_fits;
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign m_axis_valid = fill_q != '0;
  assign m_axis_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_axis_last  = mem_q[rd_ptr_q][DATA_WIDTH];
  assign overflow     = overflow_q;

endmodule
